sensor_node_responder: RTL and testbench
========================================

// Module: sensor_node_responder
// PURPOSE
//  Responder end of the 2-byte sensor request link: the external node that receives
//  a request frame from the monitor over UART and returns the requested measurement.
//  Sits between a uart_top instance (rx_dv/rx_byte in, tx_dv/tx_byte out) and a bank
//  of sensor value registers (4 rooms x 4 sensors, 8 bits each).
// PARAMETERS
//  CLK_FREQ_HZ        25_000_000               system clock, Hz
//  RX_TIMEOUT_CYCLES  CLK_FREQ_HZ/1000 (~1 ms) max gap byte1->byte2, in cycles
//  TURNAROUND_CYCLES  16                       idle cycles between frame decode and first reply byte
// PORTS
//  clk            in   1    system clock
//  rst_n          in   1    async reset, active low
//  rx_dv          in   1    1-cycle strobe: rx_byte valid (from uart_top o_rx_dv)
//  rx_byte        in   8    received byte
//  tx_active      in   1    UART transmitter busy
//  tx_done        in   1    1-cycle strobe: current byte fully sent
//  tx_dv          out  1    1-cycle strobe: launch tx_byte
//  tx_byte        out  8    byte to transmit; held stable until tx_done
//  sensor_data    in   128  16 values, value[r*4+s] = sensor_data[(r*4+s)*8 +: 8]
//  busy           out  1    high from byte1 accepted until last reply tx_done
//  req_valid      out  1    1-cycle pulse: valid frame decoded
//  req_room       out  2    room of last valid frame (held)
//  req_sensor     out  2    sensor of last valid frame (held)
//  err_timeout    out  1    1-cycle pulse: byte2 not received in time
//  err_header     out  1    1-cycle pulse: byte1 header invalid
//  rx_overrun     out  1    1-cycle pulse: rx_dv while replying (byte dropped)
// BEHAVIOUR
//  Single clock; reset is asynchronous and active-low. All outputs reset to 0; FSM -> IDLE.
//  Frame: byte1 = {2'b01, 2'b00, room[1:0], sensor[1:0]}; byte2 = sequence tag (any value).
//  States: IDLE, WAIT_B2, TURN, TX_B1, DONE_B1, TX_B2, DONE_B2 (+TX_CK, DONE_CK).
//  IDLE: rx_dv -> latch byte1, clear timer, busy=1, -> WAIT_B2.
//  WAIT_B2: rx_dv -> latch byte2; if byte1[7:4]==4'b0100: sample value from sensor_data
//   that same cycle, req_valid pulse, update req_room/req_sensor, reply=ACK; else
//   err_header pulse, reply=NAK; -> TURN. Timer reaching RX_TIMEOUT_CYCLES with no
//   rx_dv -> err_timeout pulse, discard frame, busy=0, -> IDLE (no reply).
//   rx_dv on the timeout cycle wins (byte accepted).
//  TURN: count TURNAROUND_CYCLES, then -> TX_B1.
//  TX_Bn: wait !tx_active, assert tx_dv 1 cycle with tx_byte set same cycle -> DONE_Bn.
//  DONE_Bn: wait tx_done -> next byte or, after last, busy=0 -> IDLE.
//  ACK reply: byte1 echoed, then sampled value (2 bytes). NAK reply: single byte 8'hEE,
//   straight to busy=0/IDLE after its tx_done.
//  rx_dv in TURN/TX_*/DONE_*: byte dropped, rx_overrun pulse, FSM unaffected.
//  Value is a snapshot: sensor_data changes after sampling do not alter the reply.
//  Timer is 32-bit, saturating; never wraps.
//  Reset mid-transmit: tx_dv deasserts immediately; partial frame discarded.
// CONFIGURATION
//  SENSOR_RESP_CHECKSUM_EN defined: ACK reply gains a 3rd byte = byte1 ^ value
//   (states TX_CK/DONE_CK); NAK unchanged. Undefined: ACK is exactly 2 bytes,
//   TX_CK/DONE_CK not present. Default build: undefined (monitor expects 2 bytes).
// STRUCTURE
//  sensor_link_pkg: HDR_NIBBLE=4'b0100, NAK_BYTE=8'hEE, ROOM_W=2, SENSOR_W=2,
//   VAL_W=8, resp_state_t enum; shared with the monitor-side request encoder.
//  Sub-module rx_frame_timer: clear/enable inputs, saturating count, timeout pulse output.
// TESTING
//  1 byte1=8'h46, byte2=8'h01, value[6]=8'h5A -> req_valid, room=1 sensor=2; tx 8'h46 then 8'h5A; busy falls after 2nd tx_done.
//  2 byte1=8'h46, no byte2 for RX_TIMEOUT_CYCLES -> err_timeout pulse, no tx_dv, busy=0, IDLE.
//  3 byte1=8'hC3, byte2=8'h00 -> err_header pulse; single tx 8'hEE; no req_valid.
//  4 frame 8'h4F/8'h02, inject rx_dv 8'h33 during TX_B1 -> rx_overrun pulse; reply still 8'h4F, value[15].
//  5 rst_n low during DONE_B1 -> tx_dv=0, busy=0; next frame 8'h40/8'h00 answered normally with value[0].
//  6 with SENSOR_RESP_CHECKSUM_EN, frame 8'h46 value 8'h5A -> tx 8'h46, 8'h5A, 8'h1C.

Source files
------------

// File: rtl/sensor_link_pkg.sv
// Shared definitions for the 2-byte sensor request link (monitor encoder and node responder).
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: header nibble, NAK byte, field widths, request header struct,
//   responder state enum, value-bank lookup helper.
// Optional feature macro: SENSOR_RESP_CHECKSUM_EN adds the checksum reply states.
package sensor_link_pkg;

   localparam logic [3:0] HDR_NIBBLE  = 4'b0100;
   localparam logic [7:0] NAK_BYTE    = 8'hEE;
   localparam int         ROOM_W      = 2;
   localparam int         SENSOR_W    = 2;
   localparam int         VAL_W       = 8;
   localparam int         NUM_ROOMS   = 1 << ROOM_W;
   localparam int         NUM_SENSORS = 1 << SENSOR_W;
   localparam int         NUM_VALUES  = NUM_ROOMS * NUM_SENSORS;

   // Request byte 1 as seen on the wire: {hdr nibble, room, sensor}.
   typedef struct packed {
      logic [3:0]          hdr;
      logic [ROOM_W-1:0]   room;
      logic [SENSOR_W-1:0] sensor;
   } req_hdr_t;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      WAIT_B2 = 4'd1,
      TURN    = 4'd2,
      TX_B1   = 4'd3,
      DONE_B1 = 4'd4,
      TX_B2   = 4'd5,
      DONE_B2 = 4'd6
`ifdef SENSOR_RESP_CHECKSUM_EN
      ,
      TX_CK   = 4'd7,
      DONE_CK = 4'd8
`endif
   } resp_state_t;

   // value[r*NUM_SENSORS+s] lives at bits [(r*NUM_SENSORS+s)*VAL_W +: VAL_W].
   function automatic logic [VAL_W-1:0] pick_value(
      input logic [NUM_VALUES*VAL_W-1:0] data,
      input logic [ROOM_W-1:0]           room,
      input logic [SENSOR_W-1:0]         sensor
   );
      logic [NUM_VALUES-1:0][VAL_W-1:0] vals;
      vals = data;
      return vals[{room, sensor}];
   endfunction

endpackage

// File: rtl/rx_frame_timer.sv
// Inter-byte gap timer: 32-bit saturating counter with a timeout flag.
// Latency: timeout is combinational from the count; it asserts on the LIMIT-th enabled cycle after clear.
// Backpressure: none; clear has priority over enable.
// Ports: clk, rst_n (async, active low), clear (restart at zero), enable (count this cycle),
//   timeout (high while enabled and LIMIT cycles have elapsed since clear).
module rx_frame_timer #(
   parameter int unsigned LIMIT = 25_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   localparam logic [31:0] LIMIT_M1 = (LIMIT == 0) ? 32'd0 : 32'(LIMIT - 1);

   logic [31:0] count;

   // Saturates at all-ones so an abandoned frame can never wrap back under the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 32'd1;
      end
   end

   assign timeout = enable && !clear && (count >= LIMIT_M1);

endmodule

// File: rtl/sensor_node_responder.sv
// Sensor node responder: decodes a 2-byte request from the UART and replies with ACK+value or NAK.
// Latency: req_valid/err_header one cycle after byte 2; first reply byte TURNAROUND_CYCLES idle cycles later.
// Backpressure: each reply byte waits for !tx_active, then for tx_done; rx bytes during a reply are dropped (rx_overrun).
// Ports: clk, rst_n; rx_dv/rx_byte from UART rx; tx_active/tx_done from UART tx; tx_dv/tx_byte to UART tx;
//   sensor_data (16 x 8-bit bank); busy; req_valid/req_room/req_sensor; err_timeout, err_header, rx_overrun pulses.
// Optional feature macro: SENSOR_RESP_CHECKSUM_EN appends byte1^value as a third ACK byte.
module sensor_node_responder
   import sensor_link_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ       = 25_000_000,
   parameter int unsigned RX_TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000,
   parameter int unsigned TURNAROUND_CYCLES = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         rx_dv,
   input  logic [7:0]                   rx_byte,
   input  logic                         tx_active,
   input  logic                         tx_done,
   output logic                         tx_dv,
   output logic [7:0]                   tx_byte,
   input  logic [NUM_VALUES*VAL_W-1:0]  sensor_data,
   output logic                         busy,
   output logic                         req_valid,
   output logic [ROOM_W-1:0]            req_room,
   output logic [SENSOR_W-1:0]          req_sensor,
   output logic                         err_timeout,
   output logic                         err_header,
   output logic                         rx_overrun
);

   localparam int TURN_W = (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;
   localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND_CYCLES - 1);

   resp_state_t       state, state_nxt;
   req_hdr_t          byte1_q;
   logic [7:0]        byte1_raw;
   logic [VAL_W-1:0]  value_q;
   logic              reply_ack;
   logic [TURN_W-1:0] turn_cnt;

   logic              ld_b1, decode, hdr_ok;
   logic              timer_clr, timer_en, rx_timeout;
   logic              tx_launch;
   logic [7:0]        tx_byte_nxt;
   logic              err_timeout_nxt, overrun_nxt;

   assign byte1_raw = byte1_q;
   assign hdr_ok    = (byte1_q.hdr == HDR_NIBBLE);
   // Bytes arriving while the reply is being prepared or sent are not queued.
   assign overrun_nxt = rx_dv && (state != IDLE) && (state != WAIT_B2);

   rx_frame_timer #(
      .LIMIT   (RX_TIMEOUT_CYCLES)
   ) u_rx_frame_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clr),
      .enable  (timer_en),
      .timeout (rx_timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      ld_b1           = 1'b0;
      decode          = 1'b0;
      timer_clr       = 1'b0;
      timer_en        = 1'b0;
      tx_launch       = 1'b0;
      tx_byte_nxt     = tx_byte;
      err_timeout_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (rx_dv) begin
               ld_b1     = 1'b1;
               timer_clr = 1'b1;
               state_nxt = WAIT_B2;
            end
         end
         WAIT_B2: begin
            timer_en = 1'b1;
            // A byte landing on the timeout cycle still completes the frame.
            if (rx_dv) begin
               decode    = 1'b1;
               state_nxt = TURN;
            end else if (rx_timeout) begin
               err_timeout_nxt = 1'b1;
               state_nxt       = IDLE;
            end
         end
         TURN: begin
            if (turn_cnt == TURN_LAST) begin
               state_nxt = TX_B1;
            end
         end
         TX_B1: begin
            if (!tx_active) begin
               tx_launch   = 1'b1;
               tx_byte_nxt = reply_ack ? byte1_raw : NAK_BYTE;
               state_nxt   = DONE_B1;
            end
         end
         DONE_B1: begin
            if (tx_done) begin
               state_nxt = reply_ack ? TX_B2 : IDLE;
            end
         end
         TX_B2: begin
            if (!tx_active) begin
               tx_launch   = 1'b1;
               tx_byte_nxt = value_q;
               state_nxt   = DONE_B2;
            end
         end
         DONE_B2: begin
            if (tx_done) begin
`ifdef SENSOR_RESP_CHECKSUM_EN
               state_nxt = TX_CK;
`else
               state_nxt = IDLE;
`endif
            end
         end
`ifdef SENSOR_RESP_CHECKSUM_EN
         TX_CK: begin
            if (!tx_active) begin
               tx_launch   = 1'b1;
               tx_byte_nxt = byte1_raw ^ value_q;
               state_nxt   = DONE_CK;
            end
         end
         DONE_CK: begin
            if (tx_done) begin
               state_nxt = IDLE;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Registered outputs, frame capture and turnaround counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte1_q     <= '0;
         value_q     <= '0;
         reply_ack   <= 1'b0;
         turn_cnt    <= '0;
         tx_dv       <= 1'b0;
         tx_byte     <= '0;
         busy        <= 1'b0;
         req_valid   <= 1'b0;
         req_room    <= '0;
         req_sensor  <= '0;
         err_timeout <= 1'b0;
         err_header  <= 1'b0;
         rx_overrun  <= 1'b0;
      end else begin
         tx_dv       <= tx_launch;
         busy        <= (state_nxt != IDLE);
         req_valid   <= decode && hdr_ok;
         err_header  <= decode && !hdr_ok;
         err_timeout <= err_timeout_nxt;
         rx_overrun  <= overrun_nxt;
         turn_cnt    <= (state == TURN) ? turn_cnt + 1'b1 : '0;
         if (tx_launch) begin
            tx_byte <= tx_byte_nxt;
         end
         if (ld_b1) begin
            byte1_q <= rx_byte;
         end
         if (decode) begin
            reply_ack <= hdr_ok;
            // Value is frozen here; later bank updates do not reach this reply.
            if (hdr_ok) begin
               value_q    <= pick_value(sensor_data, byte1_q.room, byte1_q.sensor);
               req_room   <= byte1_q.room;
               req_sensor <= byte1_q.sensor;
            end
         end
      end
   end

endmodule

// File: tb/tb_sensor_node_responder.sv
// Bench for sensor_node_responder: directed frames, a UART transmitter model,
// a frame-level reply model and one per-cycle compare process.
module tb_sensor_node_responder;

   localparam int RX_TO    = 100;
   localparam int TURN     = 16;
   localparam int UART_CYC = 10;
   localparam int K_NONE = 0, K_ACK = 1, K_NAK = 2, K_TO = 3;

   logic         clk;
   logic         rst_n;
   logic         rx_dv;
   logic [7:0]   rx_byte;
   logic         tx_active;
   logic         tx_done;
   logic         tx_dv;
   logic [7:0]   tx_byte;
   logic [127:0] sensor_data;
   logic         busy;
   logic         req_valid;
   logic [1:0]   req_room;
   logic [1:0]   req_sensor;
   logic         err_timeout;
   logic         err_header;
   logic         rx_overrun;

   sensor_node_responder #(
      .RX_TIMEOUT_CYCLES (RX_TO),
      .TURNAROUND_CYCLES (TURN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_dv       (rx_dv),
      .rx_byte     (rx_byte),
      .tx_active   (tx_active),
      .tx_done     (tx_done),
      .tx_dv       (tx_dv),
      .tx_byte     (tx_byte),
      .sensor_data (sensor_data),
      .busy        (busy),
      .req_valid   (req_valid),
      .req_room    (req_room),
      .req_sensor  (req_sensor),
      .err_timeout (err_timeout),
      .err_header  (err_header),
      .rx_overrun  (rx_overrun)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model state
   logic [7:0] exp_tx[$];
   logic [7:0] tx_log[$];
   int         exp_kind;
   logic [1:0] exp_room, exp_sensor;
   int n_req = 0, n_hdr = 0, n_to = 0, n_ovr = 0;
   int decode_cyc = 0, busy_rise_cyc = 0;
   bit first_pending = 0;
   bit busy_q = 0;
   logic [7:0] last_tx = 8'h00;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // UART transmitter: busy for UART_CYC cycles per byte, then a tx_done strobe.
   int uart_cnt = 0;
   initial begin
      tx_active = 1'b0;
      tx_done   = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tx_done = 1'b0;
         if (!rst_n) begin
            uart_cnt  = 0;
            tx_active = 1'b0;
         end else if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
               tx_active = 1'b0;
               tx_done   = 1'b1;
            end
         end else if (tx_dv) begin
            tx_active = 1'b1;
            uart_cnt  = UART_CYC;
         end
      end
   end

   // Reply model: what the node must send back for a given byte 1.
   task automatic expect_frame(input logic [7:0] b1);
      logic [7:0] v;
      if (b1[7:4] == 4'b0100) begin
         v          = sensor_data[(b1[3:2] * 4 + b1[1:0]) * 8 +: 8];
         exp_kind   = K_ACK;
         exp_room   = b1[3:2];
         exp_sensor = b1[1:0];
         exp_tx.push_back(b1);
         exp_tx.push_back(v);
`ifdef SENSOR_RESP_CHECKSUM_EN
         exp_tx.push_back(b1 ^ v);
`endif
      end else begin
         exp_kind = K_NAK;
         exp_tx.push_back(8'hEE);
      end
   endtask

   // Compare process
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_tx.delete();
         first_pending = 0;
         busy_q        = 0;
      end else begin
         if (busy && !busy_q) busy_rise_cyc = cyc;
         busy_q = busy;
         if (req_valid) begin
            n_req++;
            check_eq("req_room", req_room, exp_room);
            check_eq("req_sensor", req_sensor, exp_sensor);
            decode_cyc    = cyc;
            first_pending = 1;
         end
         if (err_header) begin
            n_hdr++;
            decode_cyc    = cyc;
            first_pending = 1;
         end
         if (err_timeout) begin
            n_to++;
            check_eq("timeout_latency", cyc - busy_rise_cyc, RX_TO);
         end
         if (rx_overrun) n_ovr++;
         if (tx_dv) begin
            tx_log.push_back(tx_byte);
            last_tx = tx_byte;
            if (exp_tx.size() == 0) begin
               check_eq("unexpected_tx", {24'h0, tx_byte}, 32'hFFFF_FFFF);
            end else begin
               check_eq("tx_byte", tx_byte, exp_tx.pop_front());
            end
            if (first_pending) begin
               check_eq("turnaround", cyc - decode_cyc, TURN + 1);
               first_pending = 0;
            end
         end else if (tx_active) begin
            check_eq("tx_hold", tx_byte, last_tx);
         end
         if (tx_dv || tx_active) check_eq("busy_in_tx", busy, 1);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_byte = b;
      rx_dv   = 1'b1;
      @(posedge clk);
      #1;
      rx_dv   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done();
      bit done = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (exp_tx.size() == 0 && !busy && !tx_active) begin
            done = 1;
            break;
         end
      end
      check_eq("wait_done", done, 1);
      @(posedge clk);
      #1;
   endtask

   int b_req, b_hdr, b_to, b_ovr, b_log;
   task automatic start_test();
      b_req = n_req; b_hdr = n_hdr; b_to = n_to; b_ovr = n_ovr; b_log = tx_log.size();
   endtask

   task automatic end_test(input int req, input int hdr, input int to, input int ovr, input int ntx);
      check_eq("req_count", n_req - b_req, req);
      check_eq("hdr_count", n_hdr - b_hdr, hdr);
      check_eq("timeout_count", n_to - b_to, to);
      check_eq("overrun_count", n_ovr - b_ovr, ovr);
      check_eq("tx_count", tx_log.size() - b_log, ntx);
      check_eq("busy_idle", busy, 0);
   endtask

   task automatic check_log(input int idx, input logic [7:0] v);
      if (tx_log.size() > b_log + idx) check_eq("log_literal", tx_log[b_log + idx], v);
      else check_eq("log_missing", 32'hDEAD, {24'h0, v});
   endtask

`ifdef SENSOR_RESP_CHECKSUM_EN
   localparam int ACK_LEN = 3;
`else
   localparam int ACK_LEN = 2;
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
      exp_kind = K_NONE; exp_room = 2'd0; exp_sensor = 2'd0;
      for (int i = 0; i < 16; i++) sensor_data[i*8 +: 8] = 8'(i * 17);
      sensor_data[6*8 +: 8]  = 8'h5A;
      sensor_data[15*8 +: 8] = 8'hC7;
      sensor_data[0*8 +: 8]  = 8'h81;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      check_eq("rst_tx_dv", tx_dv, 0);
      check_eq("rst_tx_byte", tx_byte, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_pulses", {req_valid, err_timeout, err_header, rx_overrun}, 0);
      check_eq("rst_req", {req_room, req_sensor}, 0);
      rst_n = 1'b1;
      idle(1);

      // 1: ACK for room 1 sensor 2; bank change after sampling must not leak
      start_test();
      expect_frame(8'h46);
      send_byte(8'h46);
      idle(2);
      send_byte(8'h01);
      sensor_data[6*8 +: 8] = 8'hFF;
      wait_done();
      check_log(0, 8'h46);
      check_log(1, 8'h5A);
`ifdef SENSOR_RESP_CHECKSUM_EN
      check_log(2, 8'h1C);
`endif
      end_test(1, 0, 0, 0, ACK_LEN);
      check_eq("held_room", req_room, 1);
      check_eq("held_sensor", req_sensor, 2);

      // 2: byte 2 never arrives
      start_test();
      exp_kind = K_TO;
      send_byte(8'h46);
      wait_done();
      end_test(0, 0, 1, 0, 0);

      // 3: bad header -> single NAK byte
      start_test();
      expect_frame(8'hC3);
      send_byte(8'hC3);
      idle(1);
      send_byte(8'h00);
      wait_done();
      check_log(0, 8'hEE);
      end_test(0, 1, 0, 0, 1);
      check_eq("nak_keeps_room", req_room, 1);
      check_eq("nak_keeps_sensor", req_sensor, 2);

      // 4: stray byte while the reply starts
      start_test();
      expect_frame(8'h4F);
      send_byte(8'h4F);
      send_byte(8'h02);
      idle(TURN);
      send_byte(8'h33);
      wait_done();
      check_log(0, 8'h4F);
      check_log(1, 8'hC7);
      end_test(1, 0, 0, 1, ACK_LEN);

      // 5: reset while the first reply byte is being launched
      start_test();
      expect_frame(8'h46);
      send_byte(8'h46);
      send_byte(8'h07);
      begin
         bit seen = 0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_dv) begin
               seen = 1;
               break;
            end
         end
         check_eq("reset_tx_seen", seen, 1);
      end
      #2 rst_n = 1'b0;
      #1;
      check_eq("midrst_tx_dv", tx_dv, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_req", {req_room, req_sensor}, 0);
      repeat (3) @(posedge clk);
      #5 rst_n = 1'b1;
      idle(1);
      check_eq("after_rst_tx_count", tx_log.size() - b_log, 1);

      // 6: normal frame after reset
      start_test();
      expect_frame(8'h40);
      send_byte(8'h40);
      send_byte(8'h00);
      wait_done();
      check_log(0, 8'h40);
      check_log(1, 8'h81);
      end_test(1, 0, 0, 0, ACK_LEN);
      check_eq("room0", {req_room, req_sensor}, 0);

      // 7: byte 2 on the very cycle the timeout would fire is accepted
      start_test();
      expect_frame(8'h4B);
      send_byte(8'h4B);
      idle(RX_TO - 1);
      send_byte(8'h55);
      wait_done();
      check_log(0, 8'h4B);
      check_log(1, 8'hBB);
      end_test(1, 0, 0, 0, ACK_LEN);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
